// File: rtl/raw_readout_ctrl_if.sv
// Readout word stream from raw_readout_ctrl to the DAQ sink.
// A word transfers on a cycle where daq_valid and daq_ready are both high.
interface raw_readout_ctrl_if;
  logic [15:0] daq_data;
  logic        daq_valid;
  logic        daq_ready;
  logic        daq_last;

  modport master (output daq_data, output daq_valid, output daq_last, input daq_ready);
  modport slave  (input daq_data, input daq_valid, input daq_last, output daq_ready);
endinterface

// File: rtl/raw_readout_ctrl.sv
// Raw readout controller: drives the raw delay memory, captures 1..4 delayed frames per
// accepted trigger and streams a header word plus the frames as 16-bit words.
module raw_readout_ctrl #(
  parameter int NWORD = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                l1a,
  input  logic [1:0]          nbins_cfg,
  input  logic [7:0]          delay_cfg,
  input  logic [191:0]        rd_dout,
  output logic                rd_we,
  output logic                rd_trig_stop,
  output logic [7:0]          rd_delay,
  raw_readout_ctrl_if.master  daq,
  output logic                busy,
  output logic [7:0]          l1a_cnt,
  output logic [7:0]          drop_cnt
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_CAPTURE, ST_HEADER, ST_SEND} state_t;

  localparam logic [3:0] LAST_WRD = 4'(NWORD - 1);

  state_t       state_r, state_next_s;
  logic [1:0]   nb_r, frm_r, frm_next_s;
  logic [3:0]   wrd_r, wrd_next_s;
  logic [7:0]   hdr_cnt_r, l1a_cnt_r, drop_cnt_r, rd_delay_r;
  logic         rst_d_r, run_en_d_r, trig_stop_r, trig_stop_next_s, rd_we_r;
  logic         accept_s, hs_s;
  logic [15:0]  data_next_s, data_r;
  logic         valid_next_s, valid_r, last_next_s, last_r, busy_r;
  logic [191:0] frame_buf_r [4];

  function automatic logic [15:0] sel_word(input logic [191:0] frame, input logic [3:0] idx);
    sel_word = frame[{idx, 4'h0} +: 16];
  endfunction

  // Trigger acceptance, handshake and next-state/next-output decode
  always_comb begin
    trig_stop_next_s = rst | rst_d_r | (run_en & ~run_en_d_r);
    accept_s         = l1a & run_en & ~trig_stop_r & (state_r == ST_IDLE);
    hs_s             = valid_r & daq.daq_ready;
    state_next_s     = state_r;
    frm_next_s       = frm_r;
    wrd_next_s       = wrd_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        state_next_s = ST_CAPTURE;
        frm_next_s   = 2'd0;
      end
      ST_CAPTURE: begin
        if (frm_r == nb_r) begin
          state_next_s = ST_HEADER;
          frm_next_s   = 2'd0;
        end else begin
          frm_next_s   = frm_r + 2'd1;
        end
      end
      ST_HEADER: begin
        if (hs_s) begin
          state_next_s = ST_SEND;
          frm_next_s   = 2'd0;
          wrd_next_s   = 4'd0;
        end else begin
          state_next_s = ST_HEADER;
        end
      end
      ST_SEND: begin
        if (hs_s && last_r) begin
          state_next_s = ST_IDLE;
        end else if (hs_s && (wrd_r == LAST_WRD)) begin
          wrd_next_s   = 4'd0;
          frm_next_s   = frm_r + 2'd1;
        end else if (hs_s) begin
          wrd_next_s   = wrd_r + 4'd1;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase

    // Outputs are precomputed for the coming state so they leave a register
    valid_next_s = 1'b0;
    last_next_s  = 1'b0;
    data_next_s  = 16'h0000;
    case (state_next_s)
      ST_HEADER: begin
        valid_next_s = 1'b1;
        data_next_s  = {4'hA, 2'b00, nb_r, hdr_cnt_r};
      end
      ST_SEND: begin
        valid_next_s = 1'b1;
        data_next_s  = sel_word(frame_buf_r[frm_next_s], wrd_next_s);
        last_next_s  = (frm_next_s == nb_r) && (wrd_next_s == LAST_WRD);
      end
      default: begin
        valid_next_s = 1'b0;
        last_next_s  = 1'b0;
        data_next_s  = 16'h0000;
      end
    endcase
  end

  // Control state, counters and registered readout outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      frm_r      <= 2'd0;
      wrd_r      <= 4'd0;
      nb_r       <= 2'd0;
      hdr_cnt_r  <= 8'd0;
      l1a_cnt_r  <= 8'd0;
      drop_cnt_r <= 8'd0;
      rd_delay_r <= 8'd0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      data_r     <= 16'h0000;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      frm_r   <= frm_next_s;
      wrd_r   <= wrd_next_s;
      valid_r <= valid_next_s;
      last_r  <= last_next_s;
      data_r  <= data_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (accept_s) begin
        nb_r      <= nbins_cfg;
        hdr_cnt_r <= l1a_cnt_r;
        l1a_cnt_r <= l1a_cnt_r + 8'd1;
      end
      if (l1a && !accept_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      if (state_r == ST_IDLE) begin
        rd_delay_r <= delay_cfg;
      end
    end
  end

  // Delay-memory strobes; rd_we uses the upcoming strobe so the two never overlap
  always_ff @(posedge clk) begin
    rst_d_r     <= rst;
    run_en_d_r  <= run_en;
    trig_stop_r <= trig_stop_next_s;
    rd_we_r     <= run_en & ~rst & ~trig_stop_next_s;
  end

  // Frame buffer: contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    if (state_r == ST_CAPTURE) begin
      frame_buf_r[frm_r] <= rd_dout;
    end
  end

  assign rd_we         = rd_we_r;
  assign rd_trig_stop  = trig_stop_r;
  assign rd_delay      = rd_delay_r;
  assign daq.daq_data  = data_r;
  assign daq.daq_valid = valid_r;
  assign daq.daq_last  = last_r;
  assign busy          = busy_r;
  assign l1a_cnt       = l1a_cnt_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: doc/raw_readout_ctrl.md
RAW_READOUT_CTRL -- requirements
Module: raw_readout_ctrl

Interface
REQ-001 Parameter: NWORD, default 12, 16-bit words per 192-bit frame (fixed; other values unsupported).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run_en  in  1  enables raw recording and trigger acceptance.
REQ-005 l1a  in  1  trigger pulse; one cycle per trigger.
REQ-006 nbins_cfg  in  2  time bins to read per trigger, minus 1 (0..3 -> 1..4 bins).
REQ-007 delay_cfg  in  8  requested raw-delay depth in clk cycles.
REQ-008 rd_dout  in  192  delayed raw frame from the raw delay memory.
REQ-009 rd_we  out  1  write enable to the raw delay memory.
REQ-010 rd_trig_stop  out  1  address-reset strobe to the raw delay memory.
REQ-011 rd_delay  out  8  delay value driven to the raw delay memory.
REQ-012 daq_data  out  16  readout word.
REQ-013 daq_valid  out  1  daq_data valid.
REQ-014 daq_ready  in  1  sink accepts the word when daq_valid & daq_ready.
REQ-015 daq_last  out  1  marks the final word of a readout.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 l1a_cnt  out  8  accepted-trigger counter.
REQ-018 drop_cnt  out  8  dropped-trigger counter.

Function
REQ-019 States: IDLE, WAIT, CAPTURE, HEADER, SEND; no other state is reachable.
REQ-020 rd_we SHALL equal registered (run_en & ~rst & ~rd_trig_stop).
REQ-021 rd_trig_stop SHALL be high during rst and for exactly one cycle after rst deasserts.
REQ-022 rd_trig_stop SHALL also pulse one cycle on a run_en 0->1 edge.
REQ-023 rd_delay SHALL load delay_cfg only in IDLE; changes while busy take effect on return to IDLE.
REQ-024 l1a accepted only when IDLE, run_en=1, rd_trig_stop=0; acceptance latches nbins_cfg into nb and moves to WAIT.
REQ-025 On acceptance, l1a_cnt increments modulo 256; the header carries the pre-increment value.
REQ-026 l1a while busy or run_en=0: no state change; drop_cnt increments, saturating at 255.
REQ-027 WAIT lasts exactly 1 cycle; CAPTURE lasts nb+1 cycles.
REQ-028 CAPTURE: cycle k (k=0..nb) stores rd_dout into frame buffer entry k (4 x 192 bits).
REQ-029 First captured frame is rd_dout sampled 2 cycles after the l1a cycle.
REQ-030 HEADER: daq_valid=1, daq_data = {4'hA, 2'b00, nb, l1a_cnt_at_accept}; leaves on handshake.
REQ-031 SEND: emits (nb+1)*NWORD words, frame 0 first.
REQ-032 Within each frame, word j = frame[16j+15:16j], j=0..11.
REQ-033 daq_data and daq_valid SHALL hold stable while daq_valid=1 and daq_ready=0.
REQ-034 daq_last=1 only on the final SEND word; its handshake returns to IDLE the next cycle.
REQ-035 A new l1a in the return-to-IDLE cycle counts as dropped.
REQ-036 Outside HEADER/SEND: daq_valid=0, daq_last=0, daq_data=0.
REQ-037 run_en falling mid-readout SHALL NOT abort it; the readout completes.

Reset
REQ-038 On rst: state=IDLE; busy=0, daq_valid=0, daq_last=0, daq_data=0; l1a_cnt=0, drop_cnt=0; rd_delay=0; rd_we=0; rd_trig_stop=1; frame buffer contents don't-care.
REQ-039 rst in any state SHALL abort the readout immediately, with no further daq_valid.

Verification
REQ-040 Bench: rst 3 cycles, run_en=1 -> rd_trig_stop high through the cycle after rst, rd_we=1 from the next cycle, all counters 0.
REQ-041 Bench: nbins_cfg=0, l1a, daq_ready=1 -> header 16'hA000 then 12 words equal to rd_dout sampled at l1a+2; daq_last on word 12; busy low afterwards.
REQ-042 Bench: nbins_cfg=3, rd_dout = cycle-count pattern, random daq_ready -> 48 data words from 4 consecutive frames, header 16'hA300, data held stable while stalled.
REQ-043 Bench: 3 l1a pulses during a readout, then 300 l1a pulses with run_en=0 -> drop_cnt=255 (saturated); l1a_cnt unchanged by drops.
REQ-044 Bench: delay_cfg changed 5->9 mid-readout -> rd_delay stays 5 until IDLE, then becomes 9.
REQ-045 Bench: rst asserted mid-SEND -> daq_valid=0 the next cycle; 257 later accepted triggers -> header l1a field wraps 255 -> 0.
